gpio_irq: RTL
=============

Name: gpio_irq

Overview:
Parametrised second-generation GPIO slave on the MMIO slot bus, driving NUM_OUTPUT LEDs and sampling NUM_INPUT buttons/switches.
Adds per-pin debouncing, atomic set/clear of outputs, and per-pin rising/falling edge interrupts with a sticky W1C status register.
Produces one level interrupt line to the interrupt controller.
Uses the same IDLE/ACTIVE/DONE slot handshake as the other MMIO slaves.

Parameters:
NUM_INPUT, 9, number of input pins (1..32)
NUM_OUTPUT, 4, number of output pins (1..32)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept an input change (>=1)

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
chip_select  in  1  slot select
read  in  1  read request
write  in  1  write request
transaction_completed  in  1  master acknowledge; releases DONE
addr  in  8  byte address
wr_data  in  32  write data
rd_data  out  32  read data, zero-extended
wr_done  out  1  write completion pulse
rd_done  out  1  read completion pulse
idle  out  1  high when FSM is in IDLE
slave_error  out  1  illegal access direction
decode_error  out  1  unmapped or misaligned address
irq  out  1  OR of (IRQ_STATUS) bits
in_ports  in  NUM_INPUT  raw asynchronous inputs
out_ports  out  NUM_OUTPUT  output pins

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (arst_n).
- Reset values: all outputs 0 except idle=1. Internal registers 0, state IDLE, debounce counters 0.
- Register map (word-aligned):
  - 0x00 OUT_DATA: RW.
  - 0x04 OUT_SET: write-only, W1S.
  - 0x08 OUT_CLR: write-only, W1C.
  - 0x0C IN_DATA: read-only, debounced value.
  - 0x10 RISE_EN: RW.
  - 0x14 FALL_EN: RW.
  - 0x18 IRQ_STATUS: read, W1C.
- Access errors:
  - Read of a write-only register or write of a read-only register -> slave_error, with the matching done asserted; no state change.
  - addr[1:0]!=0 or addr>0x18 -> decode_error, with the matching done asserted.
- Write data: bits above the register width are ignored. Reads zero-extend.
- FSM:
  - IDLE -> ACTIVE when chip_select && (read||write).
  - ACTIVE -> DONE unconditionally; all decoding happens in ACTIVE.
  - DONE -> IDLE when transaction_completed.
- Request priority: if read and write are both high, write wins.
- Latency: register updates, rd_data, and errors are registered at the ACTIVE->DONE edge.
  - wr_done/rd_done are high only in the first DONE cycle.
  - rd_data, slave_error and decode_error hold through DONE and clear to 0 on the edge into IDLE.
- Input path: 2-flop synchroniser per pin, then a debouncer. The debouncer adopts a new value after the synchronised sample has differed from the stable value for DEBOUNCE_CYCLES consecutive cycles. Any intermediate match resets its counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - A 1-cycle glitch never reaches IN_DATA.
- Edge detect on the debounced value: rise[i] = stable & ~stable_q; fall[i] = ~stable & stable_q.
- IRQ_STATUS[i] sets on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - A W1C to a bit on the same cycle as a set event: set wins.
  - Disabling an enable does not clear pending status.
- irq is registered: high the cycle after any status bit is 1.
- Reset mid-transaction: FSM returns to IDLE, all state is cleared, and no done is emitted.

Decomposition:
- gpio_pkg holds:
  - the state enum (IDLE, ACTIVE, DONE);
  - register address localparams (GPIO_OUT_DATA=8'h00 ... GPIO_IRQ_STATUS=8'h18);
  - GPIO_MAX_WIDTH=32.
- Sub-module gpio_debounce: one-bit synchroniser plus debouncer with a DEBOUNCE_CYCLES parameter, instantiated NUM_INPUT times via generate.
- Edge detect, interrupt logic, register file and FSM live in gpio_irq.

Test Plan:
- Write 0x5 to 0x00, then 0x2 to 0x04, then 0x4 to 0x08 -> out_ports 0x5, 0x7, 0x3. Each write gives wr_done for 1 cycle in DONE and no errors. Read 0x00 -> rd_data 0x3.
- in_ports[2] 0->1 held 10 cycles, RISE_EN=0x004 -> IN_DATA[2]=1 exactly 2+DEBOUNCE_CYCLES cycles after the change. IRQ_STATUS=0x004; irq=1 one cycle later. Write 0x004 to 0x18 -> status 0, irq 0.
- in_ports[0] pulse 0->1->0 with the high lasting 3 cycles (< DEBOUNCE_CYCLES) -> IN_DATA unchanged, IRQ_STATUS stays 0, irq stays 0.
- FALL_EN=0x1FF, release a held in_ports[8] -> IRQ_STATUS=0x100. A W1C of 0x100 issued on the same cycle as a new fall event on pin 8 -> status bit 8 remains 1.
- Read 0x04 -> slave_error=1 and rd_done=1. Write 0x0C -> slave_error=1, IN_DATA unaffected. Access 0x1C or 0x02 -> decode_error=1 with done. Errors hold until transaction_completed, then return to 0 with idle=1.
- arst_n low during DONE -> all outputs 0 immediately, idle=1. The next transaction completes normally.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared types and register map for the GPIO interrupt slave
package gpio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } gpio_state_e;

    localparam logic [7:0] GPIO_OUT_DATA   = 8'h00;
    localparam logic [7:0] GPIO_OUT_SET    = 8'h04;
    localparam logic [7:0] GPIO_OUT_CLR    = 8'h08;
    localparam logic [7:0] GPIO_IN_DATA    = 8'h0C;
    localparam logic [7:0] GPIO_RISE_EN    = 8'h10;
    localparam logic [7:0] GPIO_FALL_EN    = 8'h14;
    localparam logic [7:0] GPIO_IRQ_STATUS = 8'h18;

    localparam int GPIO_MAX_WIDTH = 32;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - two-flop synchroniser followed by a consecutive-sample debouncer
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic arst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // The counter tracks consecutive disagreeing samples; any agreeing sample restarts it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync_q2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_q2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign dout = stable;

endmodule

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - MMIO GPIO slave with debounced inputs, atomic output updates and edge interrupts
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int NUM_INPUT       = 9,
    parameter int NUM_OUTPUT      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  chip_select,
    input  logic                  read,
    input  logic                  write,
    input  logic                  transaction_completed,
    input  logic [7:0]            addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic                  idle,
    output logic                  slave_error,
    output logic                  decode_error,
    output logic                  irq,
    input  logic [NUM_INPUT-1:0]  in_ports,
    output logic [NUM_OUTPUT-1:0] out_ports
);

    gpio_state_e state;

    logic [NUM_OUTPUT-1:0] out_data;
    logic [NUM_INPUT-1:0]  rise_en;
    logic [NUM_INPUT-1:0]  fall_en;
    logic [NUM_INPUT-1:0]  irq_status;
    logic [NUM_INPUT-1:0]  in_stable;
    logic [NUM_INPUT-1:0]  in_stable_q;
    logic [NUM_INPUT-1:0]  rise;
    logic [NUM_INPUT-1:0]  fall;
    logic [NUM_INPUT-1:0]  set_evt;
    logic [NUM_INPUT-1:0]  w1c_mask;
    logic [NUM_OUTPUT-1:0] wr_out;
    logic [NUM_INPUT-1:0]  wr_in;

    logic                      do_write;
    logic                      addr_bad;
    logic                      wr_to_ro;
    logic                      rd_from_wo;
    logic                      access_ok;
    logic [GPIO_MAX_WIDTH-1:0] rd_word;
    logic                      unused_wr_data;

    for (genvar g = 0; g < NUM_INPUT; g++) begin : g_in
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .arst_n (arst_n),
            .din    (in_ports[g]),
            .dout   (in_stable[g])
        );
    end

    assign wr_out         = wr_data[NUM_OUTPUT-1:0];
    assign wr_in          = wr_data[NUM_INPUT-1:0];
    assign unused_wr_data = ^wr_data;

    // Decode is only meaningful in ACTIVE; a simultaneous read and write is treated as a write.
    always_comb begin
        do_write   = write;
        addr_bad   = (addr[1:0] != 2'b00) || (addr > GPIO_IRQ_STATUS);
        wr_to_ro   = do_write && (addr == GPIO_IN_DATA);
        rd_from_wo = !do_write && ((addr == GPIO_OUT_SET) || (addr == GPIO_OUT_CLR));
        access_ok  = (state == ACTIVE) && !addr_bad && !wr_to_ro && !rd_from_wo;
    end

    always_comb begin
        rd_word = '0;
        case (addr)
            GPIO_OUT_DATA:   rd_word[NUM_OUTPUT-1:0] = out_data;
            GPIO_IN_DATA:    rd_word[NUM_INPUT-1:0]  = in_stable;
            GPIO_RISE_EN:    rd_word[NUM_INPUT-1:0]  = rise_en;
            GPIO_FALL_EN:    rd_word[NUM_INPUT-1:0]  = fall_en;
            GPIO_IRQ_STATUS: rd_word[NUM_INPUT-1:0]  = irq_status;
            default:         rd_word = '0;
        endcase
    end

    assign rise    = in_stable & ~in_stable_q;
    assign fall    = ~in_stable & in_stable_q;
    assign set_evt = (rise & rise_en) | (fall & fall_en);

    assign w1c_mask = (access_ok && do_write && (addr == GPIO_IRQ_STATUS)) ? wr_in : '0;

    // A new edge event in the same cycle as a W1C keeps the bit pending.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            in_stable_q <= '0;
            irq_status  <= '0;
            irq         <= 1'b0;
        end else begin
            in_stable_q <= in_stable;
            irq_status  <= (irq_status & ~w1c_mask) | set_evt;
            irq         <= |irq_status;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_data <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (access_ok && do_write) begin
            case (addr)
                GPIO_OUT_DATA: out_data <= wr_out;
                GPIO_OUT_SET:  out_data <= out_data | wr_out;
                GPIO_OUT_CLR:  out_data <= out_data & ~wr_out;
                GPIO_RISE_EN:  rise_en  <= wr_in;
                GPIO_FALL_EN:  fall_en  <= wr_in;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= IDLE;
            rd_data      <= '0;
            wr_done      <= 1'b0;
            rd_done      <= 1'b0;
            slave_error  <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (chip_select && (read || write)) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    state        <= DONE;
                    wr_done      <= do_write;
                    rd_done      <= !do_write;
                    rd_data      <= (!do_write && access_ok) ? rd_word : '0;
                    slave_error  <= !addr_bad && (wr_to_ro || rd_from_wo);
                    decode_error <= addr_bad;
                end
                DONE: begin
                    if (transaction_completed) begin
                        state        <= IDLE;
                        rd_data      <= '0;
                        slave_error  <= 1'b0;
                        decode_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign idle      = (state == IDLE);
    assign out_ports = out_data;

endmodule
